// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers per-digit BCD codes from a multiplexed, digit-strobed 7-segment bus.
// Define SEG7_ACTIVE_LOW_EN for common-anode hardware (seg_in and digit_sel active-low).
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    commit,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    sel_err
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Result packing: {legal, blank, code}; blank and illegal both report code 4'hF.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_decode = {2'b10, 4'd0};
      7'b0110000: seg_decode = {2'b10, 4'd1};
      7'b1101101: seg_decode = {2'b10, 4'd2};
      7'b1111001: seg_decode = {2'b10, 4'd3};
      7'b0110011: seg_decode = {2'b10, 4'd4};
      7'b1011011: seg_decode = {2'b10, 4'd5};
      7'b1011111: seg_decode = {2'b10, 4'd6};
      7'b1110000: seg_decode = {2'b10, 4'd7};
      7'b1111111: seg_decode = {2'b10, 4'd8};
      7'b1111011: seg_decode = {2'b10, 4'd9};
      7'b0000000: seg_decode = {2'b01, 4'hF};
      default:    seg_decode = {2'b00, 4'hF};
    endcase
  endfunction

  function automatic logic [3:0] sel_count(input logic [NUM_DIGITS-1:0] sel);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      n = n + {3'b000, sel[k]};
    end
    return n;
  endfunction

  logic [6:0]              seg_phys_s;
  logic [NUM_DIGITS-1:0]   sel_phys_s;
  logic [6:0]              smp_seg_r;
  logic [NUM_DIGITS-1:0]   smp_sel_r;
  logic [6:0]              prev_seg_r;
  logic [NUM_DIGITS-1:0]   prev_sel_r;
  state_t                  state_r;
  state_t                  state_next_s;
  logic [7:0]              cnt_r;
  logic [7:0]              cnt_next_s;
  logic [NUM_DIGITS-1:0]   seen_r;
  logic [NUM_DIGITS-1:0]   seen_or_s;
  logic [NUM_DIGITS-1:0]   seen_next_s;
  logic [4*NUM_DIGITS-1:0] bcd_r;
  logic [4*NUM_DIGITS-1:0] bcd_next_s;
  logic [NUM_DIGITS-1:0]   valid_r;
  logic [NUM_DIGITS-1:0]   valid_next_s;
  logic                    commit_r;
  logic                    frame_r;
  logic                    perr_r;
  logic                    serr_r;
  logic                    commit_s;
  logic                    frame_s;
  logic                    perr_s;
  logic                    serr_s;
  logic [3:0]              smp_count_s;
  logic                    smp_valid_s;
  logic                    same_s;
  logic [5:0]              dec_s;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_phys_s = ~seg_in;
  assign sel_phys_s = ~digit_sel;
`else
  assign seg_phys_s = seg_in;
  assign sel_phys_s = digit_sel;
`endif

  // Input sample register; reset value is an empty strobe so nothing fires after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_seg_r <= 7'd0;
      smp_sel_r <= {NUM_DIGITS{1'b0}};
    end else begin
      smp_seg_r <= seg_phys_s;
      smp_sel_r <= sel_phys_s;
    end
  end

  // Stability filter, commit decode and frame bookkeeping.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    commit_s     = 1'b0;
    serr_s       = 1'b0;
    smp_count_s  = sel_count(smp_sel_r);
    smp_valid_s  = (smp_count_s == 4'd1);
    same_s       = (smp_sel_r == prev_sel_r) && (smp_seg_r == prev_seg_r);
    dec_s        = seg_decode(smp_seg_r);

    if (!smp_valid_s) begin
      state_next_s = IDLE;
      cnt_next_s   = 8'd0;
      serr_s       = (smp_count_s > 4'd1);
    end else begin
      case (state_r)
        IDLE:    cnt_next_s = 8'd1;
        TRACK:   cnt_next_s = same_s ? ((cnt_r < STABLE_LIM) ? cnt_r + 8'd1 : cnt_r) : 8'd1;
        HOLD:    cnt_next_s = same_s ? cnt_r : 8'd1;
        default: cnt_next_s = 8'd1;
      endcase
      if ((state_r == HOLD) && same_s) begin
        state_next_s = HOLD;
      end else if (cnt_next_s == STABLE_LIM) begin
        state_next_s = HOLD;
        commit_s     = 1'b1;
      end else begin
        state_next_s = TRACK;
      end
    end

    perr_s      = commit_s && !dec_s[5] && !dec_s[4];
    seen_or_s   = commit_s ? (seen_r | smp_sel_r) : seen_r;
    frame_s     = commit_s && (&seen_or_s);
    seen_next_s = frame_s ? {NUM_DIGITS{1'b0}} : seen_or_s;

    bcd_next_s   = bcd_r;
    valid_next_s = valid_r;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      bcd_next_s[4*d +: 4] = (commit_s && smp_sel_r[d]) ? dec_s[3:0] : bcd_r[4*d +: 4];
      valid_next_s[d]      = (commit_s && smp_sel_r[d]) ? dec_s[5] : valid_r[d];
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      prev_seg_r <= 7'd0;
      prev_sel_r <= {NUM_DIGITS{1'b0}};
      seen_r     <= {NUM_DIGITS{1'b0}};
      bcd_r      <= {NUM_DIGITS{4'hF}};
      valid_r    <= {NUM_DIGITS{1'b0}};
      commit_r   <= 1'b0;
      frame_r    <= 1'b0;
      perr_r     <= 1'b0;
      serr_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      prev_seg_r <= smp_seg_r;
      prev_sel_r <= smp_sel_r;
      seen_r     <= seen_next_s;
      bcd_r      <= bcd_next_s;
      valid_r    <= valid_next_s;
      commit_r   <= commit_s;
      frame_r    <= frame_s;
      perr_r     <= perr_s;
      serr_r     <= serr_s;
    end
  end

  assign bcd_out     = bcd_r;
  assign digit_valid = valid_r;
  assign commit      = commit_r;
  assign frame_done  = frame_r;
  assign pattern_err = perr_r;
  assign sel_err     = serr_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: run-length reference model plus directed literal checks.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_in;
  logic [ND-1:0] digit_sel;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] digit_valid;
  logic          commit;
  logic          frame_done;
  logic          pattern_err;
  logic          sel_err;

  logic [ND-1:0] l_sel = '0;
  logic [6:0]    l_seg = 7'd0;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_in    = ~l_seg;
  assign digit_sel = ~l_sel;
`else
  assign seg_in    = l_seg;
  assign digit_sel = l_sel;
`endif

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit_sel(digit_sel),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .commit(commit),
    .frame_done(frame_done), .pattern_err(pattern_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_commit = 0, n_frame = 0, n_perr = 0, n_serr = 0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a digit commits exactly when a run of identical valid samples reaches SC.
  logic [ND-1:0]   pend_sel, run_sel, seen;
  logic [6:0]      pend_seg, run_seg;
  int              run_len;
  logic [4*ND-1:0] m_bcd;
  logic [ND-1:0]   m_dv;
  logic            m_commit, m_frame, m_perr, m_serr;

  initial begin
    int ones, idx;
    logic [3:0] code;
    logic legal;
    forever begin
      @(negedge clk);
      m_commit = 1'b0; m_frame = 1'b0; m_perr = 1'b0; m_serr = 1'b0;
      if (rst) begin
        run_len = 0; pend_sel = '0; pend_seg = 7'd0; seen = '0;
        m_bcd = {ND{4'hF}}; m_dv = '0;
      end else begin
        ones = $countones(pend_sel);
        if (ones != 1) begin
          run_len = 0;
          m_serr  = (ones > 1);
        end else begin
          if (run_len > 0 && pend_sel == run_sel && pend_seg == run_seg) begin
            run_len++;
          end else begin
            run_len = 1; run_sel = pend_sel; run_seg = pend_seg;
          end
          if (run_len == SC) begin
            m_commit = 1'b1;
            idx = 0;
            for (int b = 0; b < ND; b++) if (pend_sel[b]) idx = b;
            code = 4'hF; legal = 1'b0;
            for (int v = 0; v < 10; v++) if (seg_tab[v] == pend_seg) begin code = v[3:0]; legal = 1'b1; end
            m_bcd[4*idx +: 4] = code;
            m_dv[idx] = legal;
            m_perr = !legal && (pend_seg != 7'd0);
            seen[idx] = 1'b1;
            if (&seen) begin m_frame = 1'b1; seen = '0; end
          end
        end
        pend_sel = l_sel; pend_seg = l_seg;
      end
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("digit_valid", 32'(digit_valid), 32'(m_dv));
      chk("commit", 32'(commit), 32'(m_commit));
      chk("frame_done", 32'(frame_done), 32'(m_frame));
      chk("pattern_err", 32'(pattern_err), 32'(m_perr));
      chk("sel_err", 32'(sel_err), 32'(m_serr));
      if (commit === 1'b1) n_commit++;
      if (frame_done === 1'b1) n_frame++;
      if (pattern_err === 1'b1) n_perr++;
      if (sel_err === 1'b1) n_serr++;
    end
  end

  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      l_sel = sel; l_seg = seg;
    end
  endtask

  task automatic idle(input int n);
    drive('0, 7'd0, n);
  endtask

  initial begin
    int c0, f0, p0, s0, len;
    logic [ND-1:0] s;
    logic [6:0] g;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Digit 0 shows "3": no commit before the 5th edge, one pulse after it, none while held.
    c0 = n_commit;
    drive(4'b0001, 7'b1111001, 4);
    @(negedge clk);
    chk("t1_no_early_commit", 32'(commit), 32'd0);
    @(negedge clk);
    chk("t1_commit_on_time", 32'(commit), 32'd1);
    chk("t1_digit0", 32'(bcd_out[3:0]), 32'd3);
    drive(4'b0001, 7'b1111001, 4);
    idle(3);
    chk("t1_commit_once", 32'(n_commit - c0), 32'd1);
    chk("t1_valid", 32'(digit_valid), 32'h1);

    // Scan 1,2,5,9 across digits 0..3.
    f0 = n_frame;
    drive(4'b0001, seg_tab[1], 6);
    drive(4'b0010, seg_tab[2], 6);
    drive(4'b0100, seg_tab[5], 6);
    drive(4'b1000, seg_tab[9], 6);
    idle(3);
    chk("t2_bcd", 32'(bcd_out), 32'h9521);
    chk("t2_valid", 32'(digit_valid), 32'hF);
    chk("t2_frame_once", 32'(n_frame - f0), 32'd1);

    // Glitch on digit 1 restarts the filter.
    c0 = n_commit; p0 = n_perr;
    drive(4'b0010, 7'b0110011, 3);
    drive(4'b0010, 7'b0110111, 1);
    drive(4'b0010, 7'b0110011, 4);
    idle(3);
    chk("t3_commit_once", 32'(n_commit - c0), 32'd1);
    chk("t3_no_perr", 32'(n_perr - p0), 32'd0);
    chk("t3_digit1", 32'(bcd_out[7:4]), 32'd4);

    // Illegal then blank pattern on digit 2.
    c0 = n_commit; p0 = n_perr;
    drive(4'b0100, 7'b1001001, 4);
    idle(3);
    chk("t4_illegal_code", 32'(bcd_out[11:8]), 32'hF);
    chk("t4_illegal_valid", 32'(digit_valid[2]), 32'd0);
    chk("t4_perr", 32'(n_perr - p0), 32'd1);
    chk("t4_commit", 32'(n_commit - c0), 32'd1);
    p0 = n_perr;
    drive(4'b0100, 7'b0000000, 4);
    idle(3);
    chk("t4_blank_code", 32'(bcd_out[11:8]), 32'hF);
    chk("t4_blank_no_perr", 32'(n_perr - p0), 32'd0);

    // Multi-hot strobe reports sel_err; an empty strobe stays silent.
    c0 = n_commit; s0 = n_serr;
    drive(4'b0110, seg_tab[8], 1);
    idle(3);
    chk("t5_sel_err", 32'(n_serr - s0), 32'd1);
    chk("t5_no_commit", 32'(n_commit - c0), 32'd0);
    s0 = n_serr;
    idle(4);
    chk("t5_zero_silent", 32'(n_serr - s0), 32'd0);

    // Asynchronous reset with cnt=3 on digit 3.
    drive(4'b1000, seg_tab[7], 3);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("t6_rst_valid", 32'(digit_valid), 32'd0);
    chk("t6_rst_pulses", 32'({commit, frame_done, pattern_err, sel_err}), 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
    l_sel = '0; l_seg = 7'd0; rst = 1'b0;
    c0 = n_commit;
    drive(4'b1000, seg_tab[7], 3);
    idle(3);
    chk("t6_no_commit_short", 32'(n_commit - c0), 32'd0);
    drive(4'b1000, seg_tab[7], 4);
    idle(3);
    chk("t6_commit_fresh", 32'(n_commit - c0), 32'd1);
    chk("t6_digit3", 32'(bcd_out[15:12]), 32'd7);

    // Randomized scanning, glitches and strobe faults against the model.
    g = seg_tab[0];
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0: s = '0;
        1: begin
          do s = 4'($urandom_range(0, 15)); while ($countones(s) < 2);
        end
        default: s = 4'(1 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        7: g = 7'd0;
        8: g = 7'($urandom_range(0, 127));
        9: g = g;
        default: g = seg_tab[$urandom_range(0, 9)];
      endcase
      len = $urandom_range(1, 7);
      drive(s, g, len);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
